top_a1_q4_decoder_3x8_seq: RTL and testbench

TOP_A1_Q4_DECODER_3X8_SEQ -- requirements
Module: top_a1_q4_decoder_3x8_seq

---
 rtl/top_a1_q4_decoder_3x8_seq.sv | 131 +++++++++++++
 tb/tb_top_a1_q4_decoder_3x8_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/top_a1_q4_decoder_3x8_seq.sv
// 3-to-8 one-hot decoder behind a small code FIFO with a valid/ready output register.
// Optional round-trip self-check selected by `DEC_ROUNDTRIP_CHK_EN (err tied low when undefined).
module top_a1_q4_decoder_3x8_seq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] I,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] O,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] level,
    output logic       err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    state_t          r_state;
    logic [2:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [4:0]      r_level;
    logic [7:0]      r_o;
    logic [2:0]      r_code;

    logic            w_push;
    logic            w_pop;
    logic [2:0]      w_head;
    logic [7:0]      w_dec;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    // Readiness depends only on the registered level, so a pop never re-opens a full FIFO.
    assign in_ready  = en && (r_level < 5'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_level != 5'd0) && ((r_state == EMPTY) || out_ready);
    assign w_head    = r_mem[r_rd_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign w_dec[gi] = (w_head == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= I;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_o     <= 8'h00;
            r_code  <= 3'd0;
        end else if (w_pop) begin
            r_state <= LOADED;
            r_o     <= w_dec;
            r_code  <= w_head;
        end else if ((r_state == LOADED) && out_ready) begin
            r_state <= EMPTY;
            r_o     <= 8'h00;
        end
    end

    assign O         = r_o;
    assign out_valid = (r_state == LOADED);
    assign level     = r_level;

`ifdef DEC_ROUNDTRIP_CHK_EN
    logic [2:0] w_enc;
    logic       w_onehot;
    logic       r_err;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        w_enc = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (O[k]) begin
                w_enc = 3'(k);
            end
        end
    end

    assign w_onehot = (O != 8'h00) && ((O & (O - 8'd1)) == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == LOADED) && (!w_onehot || (w_enc != r_code))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_top_a1_q4_decoder_3x8_seq.sv
// Randomized self-checking bench: a queue-based model of the FIFO plus output register
// predicts O, out_valid, level, in_ready and err every cycle.
module tb_top_a1_q4_decoder_3x8_seq;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] I;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] O;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: codes waiting in the FIFO, plus the code held at the output.
    int unsigned mq[$];
    bit          m_valid;
    bit [2:0]    m_code;
    bit          m_err;

    top_a1_q4_decoder_3x8_seq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .I         (I),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .O         (O),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] exp_o;
        exp_o = m_valid ? (32'd1 << m_code) : 32'd0;
        check({tag, ":O"}, 32'(O), exp_o);
        check({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ":level"}, 32'(level), 32'(mq.size()));
        check({tag, ":in_ready"}, 32'(in_ready), 32'(en && (mq.size() < DEPTH)));
        check({tag, ":err"}, 32'(err), 32'(m_err));
    endtask

    // One clock: predict from pre-edge inputs, advance the model, then compare #1 after the edge.
    task automatic tick(input string tag);
        bit push;
        bit pop;
        push = in_valid && en && (mq.size() < DEPTH);
        pop  = (mq.size() > 0) && (!m_valid || out_ready);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_code  = 3'd0;
            m_err   = 1'b0;
        end else begin
            if (pop) begin
                m_code  = 3'(mq.pop_front());
                m_valid = 1'b1;
                $display("load code=%0d O=%02h", m_code, 8'd1 << m_code);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (push) begin
                mq.push_back(32'(I));
            end
        end
        #1;
        compare_all(tag);
    endtask

    initial begin
        bit acc;
        int unsigned codes[6];
        codes = '{1, 2, 3, 4, 5, 6};
        m_valid = 1'b0;
        m_code = 3'd0;
        m_err = 1'b0;
        rst_n = 1'b0;
        en = 1'b1;
        I = 3'd0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        tick("reset");
        tick("reset");
        check("reset_level", 32'(level), 32'd0);

        // Single code 5 with the sink ready
        rst_n = 1'b1;
        I = 3'd5;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick("single_acc");
        in_valid = 1'b0;
        tick("single_out");
        check("single_O", 32'(O), 32'h20);
        check("single_valid", 32'(out_valid), 32'd1);

        // Back-to-back sweep of all codes
        for (int i = 0; i < 8; i++) begin
            I = 3'(i);
            in_valid = 1'b1;
            #0;
            check("sweep_ready", 32'(in_ready), 32'd1);
            tick("sweep");
            if (i > 0) check("sweep_O", 32'(O), 32'd1 << (i - 1));
        end
        in_valid = 1'b0;
        tick("sweep_last");
        check("sweep_last_O", 32'(O), 32'h80);
        tick("drain");

        // Fill with a stalled sink
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            I = 3'(codes[i]);
            in_valid = 1'b1;
            tick("fill");
        end
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_O", 32'(O), 32'h02);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 5 && !acc; t++) begin
            acc = in_ready;
            tick("stall_release");
        end
        check("stalled_code_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        for (int t = 0; t < 7; t++) tick("full_drain");

        // Reset while two codes are queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            I = 3'(i + 2);
            in_valid = 1'b1;
            tick("pre_rst");
        end
        in_valid = 1'b0;
        check("pre_rst_level", 32'(level), 32'd2);
        rst_n = 1'b0;
        tick("mid_rst");
        check("mid_rst_O", 32'(O), 32'h00);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        I = 3'd0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick("post_rst_acc");
        in_valid = 1'b0;
        tick("post_rst_out");
        check("post_rst_O", 32'(O), 32'h01);

        // Drop en with three codes queued
        tick("idle");
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            I = 3'(7 - i);
            in_valid = 1'b1;
            tick("en_fill");
        end
        en = 1'b0;
        #1;
        check("en_drop_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) tick("en_drain");
        check("en_drain_level", 32'(level), 32'd0);
        in_valid = 1'b0;
        en = 1'b1;

`ifdef DEC_ROUNDTRIP_CHK_EN
        // Corrupt O while code 0 is held and confirm the sticky flag
        out_ready = 1'b0;
        I = 3'd0;
        in_valid = 1'b1;
        tick("chk_acc");
        in_valid = 1'b0;
        tick("chk_load");
        force dut.O = 8'h03;
        @(posedge clk);
        #1;
        check("chk_err_set", 32'(err), 32'd1);
        release dut.O;
        m_err = 1'b1;
        #1;
        tick("chk_sticky");
        tick("chk_sticky");
        rst_n = 1'b0;
        tick("chk_rst");
        rst_n = 1'b1;
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            en        = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 2) != 0);
            I         = 3'($urandom_range(0, 7));
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
